// File: rtl/manchester_frame_rx.sv
// Frame receive stage: checks length and trailing CRC-8 of decoded byte frames, holds good
// frames in a two-slot ping-pong store and replays their payload as an AXI4-Stream.
module manchester_frame_rx #(
  parameter int unsigned FRAME_SIZE = 6
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [7:0]  decoded_byte,
  input  logic        byte_valid,
  input  logic        tx_end,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        frame_ok,
  output logic [15:0] crc_err_cnt,
  output logic [15:0] len_err_cnt,
  output logic [15:0] drop_cnt
);

  localparam int unsigned PayLen = FRAME_SIZE - 1;
  localparam int unsigned CntW   = $clog2(FRAME_SIZE + 1);
  localparam int unsigned IdxW   = (PayLen > 1) ? $clog2(PayLen) : 1;

  typedef enum logic [1:0] {StIdle, StRecv, StDiscard} rx_state_e;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Receive side state
  rx_state_e         state_q;
  logic [CntW-1:0]   wcnt_q;
  logic [7:0]        crc_q;
  logic              drop_pending_q;
  logic              len_pending_q;
  logic              wr_ptr_q;
  logic              frame_ok_q;
  logic [15:0]       crc_err_cnt_q;
  logic [15:0]       len_err_cnt_q;
  logic [15:0]       drop_cnt_q;

  // Slot store and read side state
  logic [7:0]        mem_q [2][PayLen];
  logic [1:0]        slot_full_q;
  logic              rd_ptr_q;
  logic [IdxW-1:0]   rd_cnt_q;
  logic              out_slot_q;
  logic              tvalid_q;
  logic [7:0]        tdata_q;
  logic              tlast_q;

  logic              wr_en;
  logic [IdxW-1:0]   widx;
  logic              commit;
  logic              rd_load;
  logic              rd_last;
  logic              slot_free;

  always_comb begin
    wr_en  = 1'b0;
    widx   = '0;
    commit = 1'b0;
    if (byte_valid) begin
      unique case (state_q)
        StIdle: begin
          wr_en = !slot_full_q[wr_ptr_q];
          widx  = '0;
        end
        StRecv: begin
          wr_en  = (wcnt_q < CntW'(PayLen));
          widx   = IdxW'(wcnt_q);
          commit = tx_end && (wcnt_q == CntW'(PayLen)) && (decoded_byte == crc_q);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q        <= StIdle;
      wcnt_q         <= '0;
      crc_q          <= '0;
      drop_pending_q <= 1'b0;
      len_pending_q  <= 1'b0;
      wr_ptr_q       <= 1'b0;
      frame_ok_q     <= 1'b0;
      crc_err_cnt_q  <= '0;
      len_err_cnt_q  <= '0;
      drop_cnt_q     <= '0;
    end else begin
      frame_ok_q <= commit;
      if (commit) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (byte_valid) begin
        unique case (state_q)
          StIdle: begin
            if (!slot_full_q[wr_ptr_q]) begin
              // A one-byte frame can never be the right length.
              if (tx_end) begin
                len_err_cnt_q <= sat_inc(len_err_cnt_q);
              end else begin
                state_q <= StRecv;
                wcnt_q  <= CntW'(1);
                crc_q   <= crc8_step(8'h00, decoded_byte);
              end
            end else if (tx_end) begin
              drop_cnt_q <= sat_inc(drop_cnt_q);
            end else begin
              state_q        <= StDiscard;
              drop_pending_q <= 1'b1;
              len_pending_q  <= 1'b0;
            end
          end
          StRecv: begin
            if (tx_end) begin
              state_q <= StIdle;
              if (wcnt_q != CntW'(PayLen)) begin
                len_err_cnt_q <= sat_inc(len_err_cnt_q);
              end else if (decoded_byte != crc_q) begin
                crc_err_cnt_q <= sat_inc(crc_err_cnt_q);
              end
            end else if (wcnt_q == CntW'(FRAME_SIZE)) begin
              state_q        <= StDiscard;
              drop_pending_q <= 1'b0;
              len_pending_q  <= 1'b1;
            end else begin
              wcnt_q <= wcnt_q + CntW'(1);
              if (wcnt_q < CntW'(PayLen)) begin
                crc_q <= crc8_step(crc_q, decoded_byte);
              end
            end
          end
          StDiscard: begin
            if (tx_end) begin
              state_q <= StIdle;
              if (drop_pending_q) begin
                drop_cnt_q <= sat_inc(drop_cnt_q);
              end else if (len_pending_q) begin
                len_err_cnt_q <= sat_inc(len_err_cnt_q);
              end
              drop_pending_q <= 1'b0;
              len_pending_q  <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q][widx] <= decoded_byte;
    end
  end

  assign rd_load   = !tvalid_q || m_axis_tready;
  assign rd_last   = (rd_cnt_q == IdxW'(PayLen - 1));
  assign slot_free = tvalid_q && m_axis_tready && tlast_q;

  // Commit always targets an empty slot and free always a full one, so they never collide.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      slot_full_q <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (commit && (wr_ptr_q == 1'(i))) begin
          slot_full_q[i] <= 1'b1;
        end else if (slot_free && (out_slot_q == 1'(i))) begin
          slot_full_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_ptr_q   <= 1'b0;
      rd_cnt_q   <= '0;
      out_slot_q <= 1'b0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
    end else if (rd_load) begin
      if (slot_full_q[rd_ptr_q]) begin
        tvalid_q   <= 1'b1;
        tdata_q    <= mem_q[rd_ptr_q][rd_cnt_q];
        tlast_q    <= rd_last;
        out_slot_q <= rd_ptr_q;
        if (rd_last) begin
          rd_cnt_q <= '0;
          rd_ptr_q <= ~rd_ptr_q;
        end else begin
          rd_cnt_q <= rd_cnt_q + IdxW'(1);
        end
      end else begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign frame_ok      = frame_ok_q;
  assign crc_err_cnt   = crc_err_cnt_q;
  assign len_err_cnt   = len_err_cnt_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_manchester_frame_rx.sv
// Bench for manchester_frame_rx: directed scenarios plus randomized frames and backpressure,
// scored against a frame-level model (payload queue, slot occupancy count, error tallies).
module tb_manchester_frame_rx;

  localparam int unsigned FS = 6;
  localparam int unsigned PL = FS - 1;

  logic        aclk;
  logic        aresetn;
  logic [7:0]  decoded_byte;
  logic        byte_valid;
  logic        tx_end;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        frame_ok;
  logic [15:0] crc_err_cnt;
  logic [15:0] len_err_cnt;
  logic [15:0] drop_cnt;

  manchester_frame_rx #(.FRAME_SIZE(FS)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .decoded_byte  (decoded_byte),
    .byte_valid    (byte_valid),
    .tx_end        (tx_end),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .frame_ok      (frame_ok),
    .crc_err_cnt   (crc_err_cnt),
    .len_err_cnt   (len_err_cnt),
    .drop_cnt      (drop_cnt)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [8:0] exp_q[$];
  logic [7:0] frm[$];
  int exp_crc = 0, exp_len = 0, exp_drop = 0, exp_ok = 0, ok_seen = 0;
  int outstanding = 0;
  bit rnd_ready = 0;

  // Bit-serial CRC-8 (poly 0x07, MSB first) over the first n bytes of frm.
  function automatic logic [7:0] crc_ref(input int n);
    logic [7:0] c;
    logic fb;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ frm[i][b];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
    end
    return c;
  endfunction

  task automatic make_frame(input int len, input bit bad_crc);
    logic [7:0] c;
    frm.delete();
    if (len == FS) begin
      for (int i = 0; i < PL; i++) frm.push_back(8'($urandom_range(0, 255)));
      c = crc_ref(PL);
      if (bad_crc) c = c ^ 8'($urandom_range(1, 255));
      frm.push_back(c);
    end else begin
      for (int i = 0; i < len; i++) frm.push_back(8'($urandom_range(0, 255)));
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge aclk); #1;
      byte_valid = 1'b0;
      tx_end     = 1'b0;
    end
  endtask

  // Sends frm and updates the model: no free slot at the first byte means both slots hold
  // frames whose last beat has not yet been accepted downstream.
  task automatic send_frame(input bit byte_gaps);
    bit drop;
    int n;
    n = frm.size();
    drop = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (byte_gaps && i != 0 && $urandom_range(0, 3) == 0) idle_cycles(1);
      @(posedge aclk); #1;
      decoded_byte = frm[i];
      byte_valid   = 1'b1;
      tx_end       = (i == n - 1);
      if (i == 0) drop = (outstanding >= 2);
    end
    if (drop) begin
      exp_drop++;
    end else if (n == FS && frm[FS-1] == crc_ref(PL)) begin
      for (int i = 0; i < PL; i++) exp_q.push_back({(i == PL - 1), frm[i]});
      exp_ok++;
      outstanding++;
    end else if (n == FS) begin
      exp_crc++;
    end else begin
      exp_len++;
    end
  endtask

  task automatic check_counters(input string tag);
    check_eq({tag, "_crc_err_cnt"}, 32'(crc_err_cnt), 32'(exp_crc));
    check_eq({tag, "_len_err_cnt"}, 32'(len_err_cnt), 32'(exp_len));
    check_eq({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
    check_eq({tag, "_frame_ok_pulses"}, 32'(ok_seen), 32'(exp_ok));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge aclk);
    repeat (4) @(negedge aclk);
    check_eq({tag, "_beats_left"}, 32'(exp_q.size()), 32'd0);
    check_eq({tag, "_tvalid_idle"}, 32'(m_axis_tvalid), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    check_eq({tag, "_tdata"}, 32'(m_axis_tdata), 32'd0);
    check_eq({tag, "_tlast"}, 32'(m_axis_tlast), 32'd0);
    check_eq({tag, "_frame_ok"}, 32'(frame_ok), 32'd0);
    check_eq({tag, "_crc_err_cnt"}, 32'(crc_err_cnt), 32'd0);
    check_eq({tag, "_len_err_cnt"}, 32'(len_err_cnt), 32'd0);
    check_eq({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge aclk); #1;
    aresetn    = 1'b0;
    byte_valid = 1'b0;
    tx_end     = 1'b0;
    exp_q.delete();
    exp_crc = 0; exp_len = 0; exp_drop = 0; exp_ok = 0; ok_seen = 0; outstanding = 0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check_reset_values(tag);
  endtask

  // Output monitor: scoreboard compare and stall-stability check
  bit prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic prev_last;
  logic [8:0] e;
  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (frame_ok) ok_seen++;
      if (prev_stall) begin
        check_eq("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
        check_eq("stall_tdata", 32'(m_axis_tdata), 32'(prev_data));
        check_eq("stall_tlast", 32'(m_axis_tlast), 32'(prev_last));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_beat_tdata", 32'(m_axis_tdata), 32'h100);
        end else begin
          e = exp_q.pop_front();
          check_eq("beat_tdata", 32'(m_axis_tdata), 32'(e[7:0]));
          check_eq("beat_tlast", 32'(m_axis_tlast), 32'(e[8]));
          if (e[8]) outstanding--;
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  initial begin
    forever begin
      @(posedge aclk); #1;
      if (rnd_ready) m_axis_tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int goods;
  int kind;

  initial begin
    aresetn       = 1'b0;
    decoded_byte  = 8'h00;
    byte_valid    = 1'b0;
    tx_end        = 1'b0;
    m_axis_tready = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    check_reset_values("reset");

    // Single good frame: commit and first-beat latency
    m_axis_tready = 1'b1;
    frm.delete();
    for (int i = 0; i < PL; i++) frm.push_back(8'(8'h31 + i));
    frm.push_back(crc_ref(PL));
    send_frame(1'b0);
    idle_cycles(1);
    @(negedge aclk);
    check_eq("t1_frame_ok_n1", 32'(frame_ok), 32'd1);
    check_eq("t1_tvalid_n1", 32'(m_axis_tvalid), 32'd0);
    @(negedge aclk);
    check_eq("t1_frame_ok_n2", 32'(frame_ok), 32'd0);
    check_eq("t1_tvalid_n2", 32'(m_axis_tvalid), 32'd1);
    check_eq("t1_first_tdata", 32'(m_axis_tdata), 32'h31);
    drain("t1");
    check_counters("t1");

    // CRC error then a good frame
    make_frame(FS, 1'b1);
    send_frame(1'b0);
    make_frame(FS, 1'b0);
    send_frame(1'b0);
    idle_cycles(2);
    drain("t2");
    check_counters("t2");

    // Both slots fill under backpressure; third frame dropped; no-gap drain
    m_axis_tready = 1'b0;
    for (int f = 0; f < 3; f++) begin
      make_frame(FS, 1'b0);
      send_frame(1'b0);
    end
    idle_cycles(4);
    check_counters("t3");
    @(posedge aclk); #1;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 2 * PL; i++) begin
      @(negedge aclk);
      check_eq("t3_no_gap_tvalid", 32'(m_axis_tvalid), 32'd1);
      check_eq("t3_tlast_pos", 32'(m_axis_tlast), 32'((i == PL - 1) || (i == 2 * PL - 1)));
    end
    drain("t3");

    // Short and long frames, then a good one
    make_frame(FS - 2, 1'b0);
    send_frame(1'b0);
    make_frame(FS + 1, 1'b0);
    send_frame(1'b0);
    make_frame(FS, 1'b0);
    send_frame(1'b0);
    idle_cycles(1);
    drain("t4");
    check_counters("t4");

    // Randomized frames and backpressure
    rnd_ready = 1'b1;
    goods = 0;
    for (int f = 0; f < 2000 && goods < 200; f++) begin
      kind = $urandom_range(0, 9);
      if (kind < 7) begin
        make_frame(FS, 1'b0);
        goods++;
      end else if (kind == 7) begin
        make_frame(FS, 1'b1);
      end else if (kind == 8) begin
        make_frame($urandom_range(1, FS - 1), 1'b0);
      end else begin
        make_frame($urandom_range(FS + 1, FS + 3), 1'b0);
      end
      send_frame(1'b1);
      idle_cycles($urandom_range(0, 2));
    end
    idle_cycles(1);
    rnd_ready = 1'b0;
    @(posedge aclk); #1;
    m_axis_tready = 1'b1;
    drain("t5");
    check_counters("t5");

    // Reset in the middle of a frame
    for (int i = 0; i < 3; i++) begin
      @(posedge aclk); #1;
      decoded_byte = 8'(8'hA0 + i);
      byte_valid   = 1'b1;
      tx_end       = 1'b0;
    end
    do_reset("t6a");
    make_frame(FS, 1'b0);
    send_frame(1'b0);
    idle_cycles(1);
    drain("t6a");
    check_counters("t6a");

    // Reset with both slots full and an error already counted
    m_axis_tready = 1'b0;
    make_frame(FS, 1'b1);
    send_frame(1'b0);
    for (int f = 0; f < 2; f++) begin
      make_frame(FS, 1'b0);
      send_frame(1'b0);
    end
    idle_cycles(4);
    check_counters("t6b_pre");
    do_reset("t6b");
    m_axis_tready = 1'b1;
    repeat (3) @(negedge aclk);
    check_eq("t6b_no_stale_output", 32'(m_axis_tvalid), 32'd0);
    make_frame(FS, 1'b0);
    send_frame(1'b0);
    idle_cycles(1);
    drain("t6b");
    check_counters("t6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
